sparc_ram_responder: RTL
========================

// Module: sparc_ram_responder
// PURPOSE
//   Memory-side responder for the datapath memory handshake (MOV/RW/type -> MOC).
//   Byte-addressed, big-endian RAM serving byte, halfword and word accesses.
//   Inserts programmable wait states and raises MOC when the access is complete.
//   Sits between MAR/MDR and the IR/MDR load paths, in place of a zero-latency RAM model.
// PARAMETERS
//   ADDR_W       9   address bits used; depth = 2**ADDR_W bytes (512)
//   WAIT_CYCLES  2   wait states between request capture and completion (0..15)
// PORTS
//   Clk        in   1   system clock, rising edge
//   Reset      in   1   synchronous, active-high reset
//   MOV        in   1   memory operation valid; held high until MOC seen
//   RW         in   1   1 = read, 0 = write
//   type       in   2   00 byte, 01 halfword, 10 word, 11 illegal
//   Address    in   32  byte address (from MAR); only [ADDR_W-1:0] used
//   DataIn     in   32  write data (from MDR), right-justified
//   DataOut    out  32  read data, zero-extended, right-justified
//   MOC        out  1   memory operation complete
//   Align_Err  out  1   misaligned or illegal-type access flag, valid with MOC
// BEHAVIOUR
//   Reset: state IDLE, MOC=0, Align_Err=0, DataOut=0, wait counter=0.
//     RAM array is not cleared (bench preloads it hierarchically).
//   Reset mid-operation: abort immediately; no write is performed.
//   States: IDLE, WAIT, DONE.
//   IDLE: on an edge with MOV=1, latch Address[ADDR_W-1:0], type, RW, DataIn.
//     If type=11, half addr[0]=1, or word addr[1:0]!=0: go to DONE with Align_Err=1.
//       No RAM access; DataOut unchanged.
//     Else if WAIT_CYCLES=0: perform access and go to DONE.
//     Else: go to WAIT with counter = WAIT_CYCLES-1.
//   WAIT: if MOV=0, abort to IDLE (no write, no MOC).
//     Counter=0: perform access, go to DONE. Otherwise decrement.
//   DONE: MOC=1 (registered). Align_Err is held from capture.
//     On an edge with MOV=0: MOC=0, Align_Err=0, go to IDLE.
//     A new request needs MOV low for at least one edge.
//   Latency: request edge = edge 0; MOC is high after edge WAIT_CYCLES+1.
//   Access, big-endian, A = latched address:
//     byte   R: DataOut={24'b0,mem[A]}                W: mem[A]=DataIn[7:0]
//     half   R: DataOut={16'b0,mem[A],mem[A+1]}       W: mem[A]=DataIn[15:8],
//                                                        mem[A+1]=DataIn[7:0]
//     word   R: DataOut={mem[A],..,mem[A+3]}          W: mem[A]=DataIn[31:24]..
//                                                        mem[A+3]=DataIn[7:0]
//   DataOut updates only on a successful read; writes leave it unchanged.
//   Addresses wrap modulo 2**ADDR_W (upper bits ignored, no error).
//   Inputs changing during WAIT/DONE are ignored (latched copy used).
// TESTING
//   1 Write byte 0x5A @3, then read byte @3 -> DataOut=0x0000005A, MOC after 3 edges (WAIT_CYCLES=2).
//   2 Write word 0x11223344 @8; byte reads @8..11 -> 0x11,0x22,0x33,0x44; half read @10 -> 0x00003344.
//   3 Half write @5 -> MOC=1, Align_Err=1; word read @4 shows memory unchanged; type=11 -> Align_Err=1.
//   4 Word write @0, MOV dropped after 1 edge in WAIT -> MOC never rises, mem[0..3] unchanged.
//   5 Reset pulsed in WAIT during a write -> IDLE, MOC=0, no write; Reset in DONE -> MOC=0 next edge.
//   6 Byte write 0xA5 @0x200 -> read @0 returns 0xA5; MOV held high after MOC -> no second access.

Source files
------------

// File: rtl/sparc_ram_responder.sv
// Memory-side responder for the datapath MOV/RW/type -> MOC handshake. It is a
// byte-addressed, big-endian RAM that serves byte, halfword and word accesses.
// Latency: the request edge is edge 0, and MOC is high after edge WAIT_CYCLES+1.
// A misaligned or illegal access raises MOC after edge 1, with Align_Err set.
// Backpressure: the requester holds MOV until it sees MOC. MOC stays high until
// MOV drops, and MOV must be low for at least one edge between requests.
// Ports:
//   i_clk, i_reset                    clock; synchronous active-high reset
//   i_mov, i_rw, i_type               request valid, 1=read/0=write, 00 b / 01 h / 10 w / 11 illegal
//   i_address, i_data_in              byte address (low ADDR_W bits used), right-justified write data
//   o_data_out, o_moc, o_align_err    zero-extended read data, op complete, misalign flag
module sparc_ram_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mov,
    input  logic        i_rw,
    input  logic [1:0]  i_type,
    input  logic [31:0] i_address,
    input  logic [31:0] i_data_in,
    output logic [31:0] o_data_out,
    output logic        o_moc,
    output logic        o_align_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_type;
    logic              r_rw;
    logic [31:0]       r_wdata;
    logic [3:0]        r_cnt;
    logic              r_moc;
    logic              r_align_err;
    logic [31:0]       r_data_out;
    logic [7:0]        r_mem [0:DEPTH-1];

    logic [ADDR_W-1:0] w_in_addr;
    logic              w_in_err;
    logic              w_capture;
    logic              w_access;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [1:0]        w_acc_type;
    logic              w_acc_rw;
    logic [31:0]       w_acc_wdata;
    logic [ADDR_W-1:0] w_a0, w_a1, w_a2, w_a3;
    logic [31:0]       w_rd_data;
    logic              w_unused;

    // Upper address bits are ignored, so addresses wrap modulo the RAM depth.
    assign w_unused  = &{1'b0, i_address[31:ADDR_W]};
    assign w_in_addr = i_address[ADDR_W-1:0];
    assign w_in_err  = (i_type == 2'b11) ||
                       (i_type == 2'b01 && i_address[0]) ||
                       (i_type == 2'b10 && i_address[1:0] != 2'b00);

    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_access    = 1'b0;
        w_acc_addr  = r_addr;
        w_acc_type  = r_type;
        w_acc_rw    = r_rw;
        w_acc_wdata = r_wdata;
        case (r_state)
            S_IDLE: begin
                // With zero wait states the access happens on the capture
                // edge, so the live inputs feed the RAM instead of the latches.
                w_acc_addr  = w_in_addr;
                w_acc_type  = i_type;
                w_acc_rw    = i_rw;
                w_acc_wdata = i_data_in;
                if (i_mov) begin
                    w_capture = 1'b1;
                    if (w_in_err) begin
                        w_next = S_DONE;
                    end else if (WAIT_CYCLES == 0) begin
                        w_access = 1'b1;
                        w_next   = S_DONE;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // If the requester withdraws MOV, the access is abandoned and
                // nothing is written.
                if (!i_mov) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_access = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                if (!i_mov) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_a0 = w_acc_addr;
    assign w_a1 = w_acc_addr + ADDR_W'(1);
    assign w_a2 = w_acc_addr + ADDR_W'(2);
    assign w_a3 = w_acc_addr + ADDR_W'(3);

    always_comb begin
        case (w_acc_type)
            2'b00:   w_rd_data = {24'b0, r_mem[w_a0]};
            2'b01:   w_rd_data = {16'b0, r_mem[w_a0], r_mem[w_a1]};
            default: w_rd_data = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_type      <= 2'b00;
            r_rw        <= 1'b0;
            r_wdata     <= 32'd0;
            r_cnt       <= 4'd0;
            r_moc       <= 1'b0;
            r_align_err <= 1'b0;
            r_data_out  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_addr      <= w_in_addr;
                r_type      <= i_type;
                r_rw        <= i_rw;
                r_wdata     <= i_data_in;
                r_align_err <= w_in_err;
                r_cnt       <= CNT_INIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && w_acc_rw) r_data_out <= w_rd_data;
            // MOC is registered from the DONE state. It therefore rises one
            // edge after completion and falls on the edge where MOV is seen low.
            r_moc <= (r_state == S_DONE) && (w_next == S_DONE);
            if (r_state == S_DONE && w_next == S_IDLE) r_align_err <= 1'b0;
        end
    end

    // The RAM array is not reset. A reset on the access edge suppresses the write.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_access && !w_acc_rw) begin
            case (w_acc_type)
                2'b00: r_mem[w_a0] <= w_acc_wdata[7:0];
                2'b01: begin
                    r_mem[w_a0] <= w_acc_wdata[15:8];
                    r_mem[w_a1] <= w_acc_wdata[7:0];
                end
                2'b10: begin
                    r_mem[w_a0] <= w_acc_wdata[31:24];
                    r_mem[w_a1] <= w_acc_wdata[23:16];
                    r_mem[w_a2] <= w_acc_wdata[15:8];
                    r_mem[w_a3] <= w_acc_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    assign o_data_out  = r_data_out;
    assign o_moc       = r_moc;
    assign o_align_err = r_align_err;
endmodule
